exp2_seq: RTL and testbench
===========================

EXP2_SEQ -- requirements
Module: exp2_seq

Interface
REQ-001 The module SHALL have no parameters; the fixed widths below come from exp2_pkg.
REQ-002 Ports SHALL be, in this order:
  clk    in   1   sole clock; all state changes on rising edge
  rst    in   1   reset, synchronous, active-high
  start  in   1   request; sampled only in IDLE
  x      in   21  unsigned exponent, Q5.16: x[20:16] integer 0..31, x[15:0] fraction
  busy   out  1   high while a computation is in progress (MUL, SCALE)
  valid  out  1   one-cycle pulse; y holds a new result
  y      out  48  2^x, unsigned Q32.16: y[47:16] integer, y[15:0] fraction
REQ-003 The clock SHALL be clk, and reset SHALL be rst, synchronous, active-high; there SHALL be no other clock or reset.

Function
REQ-004 The FSM SHALL have three states: IDLE, MUL, SCALE.
REQ-005 In IDLE with start=1, the block SHALL capture x into internal registers, load acc=2^30 (1.0 in Q2.30) and k=1, then go to MUL.
REQ-006 In MUL, each cycle SHALL do: if captured frac bit [16-k] is 1, acc <= (acc*C[k])>>30 (64-bit product, truncate); else acc unchanged; then k <= k+1.
REQ-007 C[k] SHALL be round(2^(2^-k) * 2^30), k=1..16, 32-bit; C[1]=0x5A82799A.
REQ-008 After the k=16 step, the FSM SHALL go to SCALE; MUL therefore lasts exactly 16 cycles whatever the fraction bits are.
REQ-009 In SCALE, the block SHALL set y <= ({acc zero-extended to 63b} << int) >> 14, truncated to 48 bits (no overflow is possible), set valid <= 1, and go to IDLE.
REQ-010 Latency SHALL be fixed: valid is high in the cycle after the 17th rising edge following the edge that sampled start.
REQ-011 valid SHALL be high for exactly one cycle; y SHALL hold its value until the next SCALE or reset.
REQ-012 busy SHALL be 1 in MUL and SCALE, and 0 in IDLE.
REQ-013 start SHALL be ignored while busy=1; x changes after capture SHALL NOT affect the result.
REQ-014 start=1 in the cycle valid=1 (state IDLE) SHALL be accepted, giving back-to-back operation every 18 cycles.
REQ-015 acc SHALL stay in [2^30, 2^31) in every cycle (result < 2.0).

Reset
REQ-016 rst=1 on a rising edge SHALL force: state=IDLE, busy=0, valid=0, y=0, acc=2^30, k=1, captured x=0.
REQ-017 rst during MUL or SCALE SHALL abort the operation with no valid pulse; rst has priority over start.

Structure
REQ-018 Package exp2_pkg SHALL hold: INT_W=5, FRAC_W=16, ACC_W=32, Y_W=48, the state enum typedef, and the C[1..16] constant array.
REQ-019 One combinational sub-module, exp2_mul, SHALL perform the 32x32 product followed by >>30 truncation; the FSM and registers SHALL be in exp2_seq.

Verification
REQ-020 x=0x00000, start pulse -> valid after 17 edges, y=0x000000010000 (1.0), busy high 17 cycles.
REQ-021 x=0x10000 (1.0) -> y=0x000000020000; x=0x1F0000 (31.0) -> y=0x800000000000.
REQ-022 x=0x08000 (0.5) -> y=0x000000016A09; x=0x0FFFF -> y within 2 LSB of 0x1FFFF (reference model: real 2^x, floor, tolerance +/-2 LSB for all random x).
REQ-023 Apply start with x=0x10000, then start with x=0x00000 at cycle 5 while busy -> second start ignored, single valid, y=0x20000; start held high in the valid cycle -> next result 18 cycles later.
REQ-024 Assert rst in MUL cycle 8 -> next cycle busy=0, valid=0, y=0, no valid pulse follows; a new start then gives a correct result.
REQ-025 Run 1000 random x with random start gaps -> every result matches the model, latency is always 17 edges, and no valid pulse occurs without a prior accepted start.

Source files
------------

// File: rtl/exp2_pkg.sv
// exp2_pkg: shared widths, FSM state type and the 2^(2^-k) coefficient table
// for the iterative 2^x unit.
//   C_TAB[k] = round(2^(2^-k) * 2^30), Q2.30, k = 1..16
package exp2_pkg;

  localparam int INT_W = 5;
  localparam int FRAC_W = 16;
  localparam int ACC_W = 32;
  localparam int Y_W = 48;
  localparam int X_W = INT_W + FRAC_W;

  // 1.0 in Q2.30
  localparam logic [ACC_W-1:0] ACC_ONE = 32'h4000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_SCALE = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] C_TAB [1:16] = '{
    32'h5A82_799A,  // 2^(1/2)
    32'h4C1B_F829,  // 2^(1/4)
    32'h45CA_E0F2,  // 2^(1/8)
    32'h42D5_61B4,
    32'h4166_C34C,
    32'h40B2_68FA,
    32'h4058_F6A8,
    32'h402C_6BE9,
    32'h4016_321B,
    32'h400B_1818,
    32'h4005_8BCE,
    32'h4002_C5D8,
    32'h4001_62E8,
    32'h4000_B173,
    32'h4000_58B9,
    32'h4000_2C5D   // 2^(1/65536)
  };

  // Out-of-range k (only seen outside MUL) maps to 1.0 so the unused
  // multiplier path never reads past the table.
  function automatic logic [ACC_W-1:0] coef(input logic [4:0] k);
    if (k >= 5'd1 && k <= 5'd16) return C_TAB[k];
    else return ACC_ONE;
  endfunction

endpackage

// File: rtl/exp2_mul.sv
// exp2_mul: combinational Q2.30 multiply, 64-bit product truncated >> 30.
//   a  in  32  accumulator, Q2.30
//   b  in  32  coefficient, Q2.30
//   p  out 32  (a*b) >> 30, truncated
// Both operands stay below 2.0, so the result always fits in 32 bits.
module exp2_mul
  import exp2_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] p
);

  assign p = ACC_W'((64'(a) * 64'(b)) >> 30);

endmodule

// File: rtl/exp2_seq.sv
// exp2_seq: sequential 2^x, x unsigned Q5.16, y unsigned Q32.16.
// The fraction is handled by multiplying 1.0 by 2^(2^-k) for each set
// fraction bit (MSB first, 16 fixed cycles); the integer part is a final
// shift in SCALE. Fixed 17-edge latency from the start-sampling edge.
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only in IDLE
//   x      in   21b exponent, Q5.16
//   busy   out  high in MUL and SCALE
//   valid  out  one-cycle pulse when y is updated
//   y      out  48b result, Q32.16, held until next SCALE or reset
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; capture x, acc=1.0, k=1 on start
// S_MUL   | 16 cycles, one fraction bit per cycle (bit 16-k)
// S_SCALE | shift acc by integer part into y, pulse valid
module exp2_seq
  import exp2_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [X_W-1:0] x,
  output logic           busy,
  output logic           valid,
  output logic [Y_W-1:0] y
);

  localparam int SH_W = ACC_W + 31;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_mul;
  logic [ACC_W-1:0]  coef_k;
  logic [4:0]        k;
  logic [X_W-1:0]    x_q;
  logic [FRAC_W-1:0] frac_q;
  logic              frac_bit;

  assign frac_q   = x_q[FRAC_W-1:0];
  assign frac_bit = frac_q[4'(5'd16 - k)];
  assign coef_k   = coef(k);

  exp2_mul u_mul (
    .a (acc),
    .b (coef_k),
    .p (acc_mul)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      y     <= '0;
      acc   <= ACC_ONE;
      k     <= 5'd1;
      x_q   <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_q   <= x;
            acc   <= ACC_ONE;
            k     <= 5'd1;
            busy  <= 1'b1;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          if (frac_bit) acc <= acc_mul;
          k <= k + 5'd1;
          if (k == 5'd16) state <= S_SCALE;
        end
        S_SCALE: begin
          // Q2.30 << int, then >> 14 lands on Q32.16; cannot exceed 48 bits
          y     <= Y_W'(({31'b0, acc} << x_q[X_W-1:FRAC_W]) >> 14);
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp2_seq.sv
// tb_exp2_seq: directed + random bench for exp2_seq with a cycle-level
// reference model and a real-valued 2^x sanity check on every result.
module tb_exp2_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [20:0] x;
  logic        busy;
  logic        valid;
  logic [47:0] y;

  int checks = 0;
  int errors = 0;

  exp2_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .busy  (busy),
    .valid (valid),
    .y     (y)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  longint unsigned coef_ref [1:16];

  function automatic longint unsigned ref_y(input logic [20:0] xv);
    longint unsigned a;
    a = 64'h4000_0000;
    for (int kk = 1; kk <= 16; kk++)
      if (xv[16-kk]) a = (a * coef_ref[kk]) >> 30;
    return ((a << xv[20:16]) >> 14) & 64'h0000_FFFF_FFFF_FFFF;
  endfunction

  // Abstract behaviour: an accepted start makes the unit busy for 17 edges,
  // the 17th edge publishes the result with a one-cycle valid.
  int          m_left = 0;
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  logic [47:0] m_y = '0;
  logic [47:0] m_pend = '0;
  logic [20:0] m_pend_x = '0;
  logic [20:0] m_x = '0;
  int          m_accepted = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left  <= 0;
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_y     <= '0;
      chk_en  <= 1'b1;
    end else begin
      m_valid <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_valid <= 1'b1;
          m_busy  <= 1'b0;
          m_y     <= m_pend;
          m_x     <= m_pend_x;
        end
      end else if (start) begin
        m_left     <= 17;
        m_busy     <= 1'b1;
        m_pend     <= 48'(ref_y(x));
        m_pend_x   <= x;
        m_accepted <= m_accepted + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    real r, d, tol;
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("valid", 64'(valid), 64'(m_valid));
      chk("y", 64'(y), 64'(m_y));
      if (m_valid) begin
        r   = $floor((2.0 ** (real'(m_x) / 65536.0)) * 65536.0);
        d   = real'(y) - r;
        if (d < 0.0) d = -d;
        // acc error of a few dozen Q2.30 LSBs grows with the integer shift
        tol = 2.0 + 64.0 * (2.0 ** (real'(m_x[20:16]) - 14.0));
        checks++;
        if (d > tol) begin
          errors++;
          $display("FAIL ideal_2x: got 0x%0h expected %f (+/-%f) for x=0x%0h", y, r, tol, m_x);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_one(input logic [20:0] xv, output int lat, output int busy_n,
                         output logic [47:0] yv);
    bit got;
    got = 1'b0; lat = -1; busy_n = 0; yv = '0;
    @(negedge clk);
    start = 1'b1; x = xv;
    for (int n = 1; n <= 60 && !got; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        x = 21'h15A5A;   // must not disturb the captured operand
      end
      if (busy) busy_n++;
      if (valid) begin
        got = 1'b1; lat = n - 1; yv = y;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout_valid: got no valid in 60 cycles, expected one for x=0x%0h", xv);
    end
  endtask

  initial begin
    int lat, bn, vcount, vn, vn2, cnt, guard, target;
    logic [47:0] yv, yv2;

    for (int kk = 1; kk <= 16; kk++)
      coef_ref[kk] = 64'($rtoi(2.0 ** (2.0 ** (-real'(kk))) * 1073741824.0 + 0.5));

    // model pinned to hand-computed values
    chk("model_x0", ref_y(21'h00000), 64'h0000_0001_0000);
    chk("model_x1", ref_y(21'h10000), 64'h0000_0002_0000);
    chk("model_x31", ref_y(21'h1F0000), 64'h8000_0000_0000);
    chk("model_xhalf", ref_y(21'h08000), 64'h0000_0001_6A09);

    rst = 1'b1; start = 1'b0; x = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_y", 64'(y), 64'd0);
    rst = 1'b0;

    run_one(21'h00000, lat, bn, yv);
    chk("x0_latency", 64'(lat), 64'd17);
    chk("x0_busy_cycles", 64'(bn), 64'd17);
    chk("x0_y", 64'(yv), 64'h0000_0001_0000);

    run_one(21'h10000, lat, bn, yv);
    chk("x1_y", 64'(yv), 64'h0000_0002_0000);
    run_one(21'h1F0000, lat, bn, yv);
    chk("x31_y", 64'(yv), 64'h8000_0000_0000);
    chk("x31_latency", 64'(lat), 64'd17);
    run_one(21'h08000, lat, bn, yv);
    chk("xhalf_y", 64'(yv), 64'h0000_0001_6A09);
    run_one(21'h0FFFF, lat, bn, yv);
    chk("x0ffff_near", 64'((yv >= 48'h1FFFD) && (yv <= 48'h20001)), 64'd1);

    // start ignored while busy, then start held in the valid cycle
    @(negedge clk);
    start = 1'b1; x = 21'h10000;
    vcount = 0; vn = 0; vn2 = 0; yv = '0; yv2 = '0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 5) begin start = 1'b1; x = 21'h00000; end
      if (n == 6) start = 1'b0;
      if (vn != 0 && n == vn + 1) start = 1'b0;
      if (valid) begin
        vcount++;
        if (vcount == 1) begin
          vn = n; yv = y;
          start = 1'b1; x = 21'h1F0000;
        end else begin
          vn2 = n; yv2 = y;
        end
      end
    end
    chk("busy_start_valid_count", 64'(vcount), 64'd2);
    chk("busy_start_latency", 64'(vn - 1), 64'd17);
    chk("busy_start_y", 64'(yv), 64'h0000_0002_0000);
    chk("b2b_spacing", 64'(vn2 - vn), 64'd18);
    chk("b2b_y", 64'(yv2), 64'h8000_0000_0000);

    // reset in MUL cycle 8 aborts the operation
    @(negedge clk);
    start = 1'b1; x = 21'h18000;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_y", 64'(y), 64'd0);
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid) cnt++;
    end
    chk("abort_no_valid", 64'(cnt), 64'd0);
    run_one(21'h08000, lat, bn, yv);
    chk("after_abort_y", 64'(yv), 64'h0000_0001_6A09);
    chk("after_abort_latency", 64'(lat), 64'd17);

    // random operands with random start activity (including while busy)
    target = m_accepted + 1000;
    guard = 0;
    while (m_accepted < target && guard < 60000) begin
      @(negedge clk);
      guard++;
      start = ($urandom_range(0, 3) == 0);
      x = 21'($urandom);
    end
    start = 1'b0;
    if (m_accepted < target) begin
      checks++; errors++;
      $display("FAIL random_budget: got %0d accepted starts, expected %0d", m_accepted, target);
    end
    repeat (25) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
